// File: rtl/wf_pkg.sv
// Shared state type and helpers for the weight fetch engine.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package wf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } wf_state_e;

  localparam logic [1:0] WF_FIFO_DEPTH = 2'd2;

  function automatic logic [1:0] fifo_occ(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry buffer between the RAM read port and the output stream.
// Accepts a push in the same cycle as a pop even when full.
module weight_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [0:1];
  logic         wptr;
  logic         rptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/weight_fetch.sv
// Weight RAM burst reader: streams len words starting at base_addr
// through a 2-entry buffer with valid/ready handshake.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module weight_fetch
  import wf_pkg::*;
#(
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

  wf_state_e         state;
  wf_state_e         state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              pend_q;
  logic              pend_last_q;
  logic              zdone_q;
  logic              accept;
  logic              accept_zero;
  logic              issue_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W:0]   fifo_dout;
  logic [1:0]        slots;

  assign accept      = (state == IDLE) && start;
  assign accept_zero = accept && (len == '0);
  assign issue_last  = (rem_q == LEN_ONE);
  assign fifo_pop    = m_valid && m_ready;

  // The pop leaving this cycle is credited so a steady consumer gets one word per cycle.
  assign slots = fifo_occ(fifo_full, fifo_empty) - {1'b0, fifo_pop} + {1'b0, pend_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !accept_zero) state_nxt = FETCH;
      FETCH:   if (ram_en && issue_last) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !pend_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en = 1'b0;
    busy   = 1'b0;
    done   = zdone_q;
    case (state)
      FETCH: begin
        busy   = 1'b1;
        ram_en = (slots < WF_FIFO_DEPTH);
      end
      DRAIN: begin
        busy = 1'b1;
        done = fifo_empty && !pend_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      zdone_q     <= accept_zero;
      pend_q      <= ram_en;
      pend_last_q <= ram_en && issue_last;
      if (accept && !accept_zero) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end else if (ram_en) begin
        addr_q <= addr_q + ADDR_ONE;
        rem_q  <= rem_q - LEN_ONE;
      end
    end
  end

  weight_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pend_q),
    .pop  (fifo_pop),
    .din  ({pend_last_q, ram_dout}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ram_we   = 1'b0;
  assign ram_addr = addr_q;
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_dout[DATA_W-1:0];
  assign m_last   = !fifo_empty && fifo_dout[DATA_W];

endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: table-driven bursts, corner
// sequences (restart, reset abort) and randomized bursts vs a list model.
`timescale 1ns/1ps
module tb_weight_fetch;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [16];
  int            ready_mode = 0;

  int n_cmp = 0;
  int n_bad = 0;

  int            cyc = 0;
  int            n_issued = 0;
  int            n_popped = 0;
  int            done_cnt = 0;
  int            busy_cycles = 0;
  int            we_cycles = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  logic [DW:0]   got [$];
  logic [AW-1:0] addrs [$];
  int            pop_cyc [$];
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word = '0;

  int s_got, s_addr, s_done, s_busy, s_we;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    int            words;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
  } vec_t;
  vec_t tbl [6];

  weight_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .ram_addr (ram_addr),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after ram_en.
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      n_popped   = n_issued;
    end else begin
      if (prev_stall) chk("stall_hold", {14'd0, m_valid, m_last, m_data}, {14'd0, 1'b1, prev_word});
      if (ram_en) begin
        chk("outstanding_le2", 32'(((n_issued - n_popped) - int'(m_valid && m_ready)) <= 1), 32'd1);
        addrs.push_back(ram_addr);
        n_issued++;
      end
      if (m_valid && m_ready) begin
        got.push_back({m_last, m_data});
        pop_cyc.push_back(cyc);
        n_popped++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cycles++;
      if (ram_we) we_cycles++;
      if (start) start_cyc = cyc;
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic snap();
    s_got  = got.size();
    s_addr = addrs.size();
    s_done = done_cnt;
    s_busy = busy_cycles;
    s_we   = we_cycles;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    len = (AW + 1)'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == s_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == s_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
    int nw = got.size() - s_got;
    int na = addrs.size() - s_addr;
    logic [AW-1:0] a;
    logic [DW:0] e;
    chk("word_count", nw, int'(l));
    for (int i = 0; i < nw && i < int'(l); i++) begin
      a = b + AW'(i);
      e = {(i == int'(l) - 1), mem[a]};
      chk("word", got[s_got + i], e);
    end
    chk("read_count", na, int'(l));
    for (int i = 0; i < na && i < int'(l); i++) begin
      a = b + AW'(i);
      chk("ram_addr", addrs[s_addr + i], a);
    end
    chk("done_pulses", done_cnt - s_done, 1);
    chk("busy_seen", 32'((busy_cycles - s_busy) != 0), 32'(l != 0));
    chk("ram_we_zero", we_cycles - s_we, 0);
    if (l == 0) chk("zero_len_done_cycle", done_cyc, start_cyc + 1);
    if (mode == 0 && l != 0 && nw == int'(l)) begin
      chk("stream_span", pop_cyc[s_got + nw - 1] - pop_cyc[s_got], int'(l) - 1);
      chk("done_after_last", done_cyc, pop_cyc[s_got + nw - 1] + 1);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
    ready_mode = mode;
    snap();
    launch(b, l);
    wait_done();
    check_burst(b, l, mode);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
    tbl[0] = '{base: 4'd0,  len: 5'd4,  mode: 0, words: 4,  first: 4'd0,  last: 4'd3};
    tbl[1] = '{base: 4'd0,  len: 5'd8,  mode: 1, words: 8,  first: 4'd0,  last: 4'd7};
    tbl[2] = '{base: 4'd14, len: 5'd4,  mode: 0, words: 4,  first: 4'd14, last: 4'd1};
    tbl[3] = '{base: 4'd5,  len: 5'd0,  mode: 0, words: 0,  first: 4'd0,  last: 4'd0};
    tbl[4] = '{base: 4'd2,  len: 5'd16, mode: 2, words: 16, first: 4'd2,  last: 4'd1};
    tbl[5] = '{base: 4'd15, len: 5'd1,  mode: 0, words: 1,  first: 4'd15, last: 4'd15};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {7'd0, ram_en, m_valid, m_last, busy, done, ram_addr, m_data}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      run_burst(tbl[k].base, tbl[k].len, tbl[k].mode);
      chk("tbl_words", got.size() - s_got, tbl[k].words);
      if (addrs.size() > s_addr) begin
        chk("tbl_first_addr", addrs[s_addr], tbl[k].first);
        chk("tbl_last_addr", addrs[addrs.size() - 1], tbl[k].last);
      end
    end

    // Start pulse while a burst is running must be ignored.
    ready_mode = 1;
    snap();
    launch(4'd3, 5'd6);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_mid", busy, 1);
    start = 1'b1;
    base_addr = 4'd9;
    len = 5'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check_burst(4'd3, 5'd6, 1);

    // Reset mid-burst, then a fresh short burst.
    ready_mode = 0;
    snap();
    launch(4'd0, 5'd8);
    t = 0;
    while ((got.size() - s_got) < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pre_reset_words", 32'((got.size() - s_got) >= 3), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {7'd0, ram_en, m_valid, m_last, busy, done, ram_addr, m_data}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_burst(4'd0, 5'd2, 0);

    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    for (int r = 0; r < 25; r++) begin
      run_burst(AW'($urandom_range(0, 15)), (AW + 1)'($urandom_range(0, 16)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
